// File: rtl/sat_pkg.sv
// Shared types and literal helpers for the 2-SAT solver pipeline.
// Literals are signed: +v is x_v, -v is the negation of x_v.
package sat_pkg;

    localparam int LIT_W = 8;

    typedef logic signed [LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        COLLECT,
        CHECK,
        DONE
    } extract_state_t;

    function automatic logic [LIT_W-1:0] lit_var(input lit_t lit);
        return lit[LIT_W-1] ? LIT_W'(-lit) : LIT_W'(lit);
    endfunction

    function automatic logic lit_ok(input lit_t lit, input int num_vars);
        return (lit != '0) && (32'(lit_var(lit)) <= num_vars);
    endfunction

endpackage

// File: rtl/literal_comp_table.sv
// Per-variable SCC index table: positive/negative comp index plus seen bits.
// One write port with polarity select, one read port addressed by variable.
module literal_comp_table #(
    parameter int NUM_VARS = 3,
    parameter int COMP_W   = 3,
    parameter int VAR_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                we,
    input  logic [VAR_W-1:0]    wr_var,
    input  logic                wr_neg,
    input  logic [COMP_W-1:0]   wr_comp,
    input  logic [VAR_W-1:0]    rd_var,
    output logic [COMP_W-1:0]   rd_pos_comp,
    output logic [COMP_W-1:0]   rd_neg_comp,
    output logic                rd_pos_seen,
    output logic                rd_neg_seen,
    output logic [NUM_VARS-1:0] pos_seen,
    output logic [NUM_VARS-1:0] neg_seen
);

    logic [COMP_W-1:0] pos_comp [NUM_VARS];
    logic [COMP_W-1:0] neg_comp [NUM_VARS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_seen <= '0;
            neg_seen <= '0;
            for (int i = 0; i < NUM_VARS; i++) begin
                pos_comp[i] <= '0;
                neg_comp[i] <= '0;
            end
        end else if (clear) begin
            pos_seen <= '0;
            neg_seen <= '0;
            for (int i = 0; i < NUM_VARS; i++) begin
                pos_comp[i] <= '0;
                neg_comp[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (wr_var == VAR_W'(i + 1)) begin
                    if (wr_neg) begin
                        neg_comp[i] <= wr_comp;
                        neg_seen[i] <= 1'b1;
                    end else begin
                        pos_comp[i] <= wr_comp;
                        pos_seen[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_pos_comp = '0;
        rd_neg_comp = '0;
        rd_pos_seen = 1'b0;
        rd_neg_seen = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (rd_var == VAR_W'(i + 1)) begin
                rd_pos_comp = pos_comp[i];
                rd_neg_comp = neg_comp[i];
                rd_pos_seen = pos_seen[i];
                rd_neg_seen = neg_seen[i];
            end
        end
    end

endmodule

// File: rtl/scc_assignment_extractor.sv
// Labels SCC-stream literals with their SCC index, then scans variables
// to decide satisfiability and emit x = (comp(x) > comp(~x)).
module scc_assignment_extractor
    import sat_pkg::*;
#(
    parameter int NUM_VARS = 3,
    parameter int LIT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic                    lit_valid,
    output logic                    lit_ready,
    input  logic signed [LIT_W-1:0] lit_in,
    input  logic                    lit_last,
    input  logic                    stream_done,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    sat,
    output logic [NUM_VARS-1:0]     assignment,
    output logic                    err_bad_lit
);

    localparam int COMP_W = $clog2(2 * NUM_VARS + 1);
    localparam int VAR_W  = $clog2(NUM_VARS + 1);
    localparam logic [COMP_W-1:0] COMP_MAX = COMP_W'(2 * NUM_VARS);

    extract_state_t state, state_nxt;

    logic [COMP_W-1:0]   comp_cnt;
    logic [VAR_W-1:0]    var_idx;
    logic [LIT_W-1:0]    v_abs;
    logic                lit_neg;
    logic                lit_in_range;
    logic                dup;
    logic                accept;
    logic                good;
    logic [COMP_W-1:0]   rd_pos_comp;
    logic [COMP_W-1:0]   rd_neg_comp;
    logic                rd_pos_seen;
    logic                rd_neg_seen;
    logic [NUM_VARS-1:0] pos_seen;
    logic [NUM_VARS-1:0] neg_seen;

    assign lit_ready    = (state == COLLECT);
    assign busy         = (state == CHECK);
    assign result_valid = (state == DONE);

    assign v_abs        = LIT_W'(lit_var(lit_t'(lit_in)));
    assign lit_neg      = lit_in[LIT_W-1];
    assign lit_in_range = lit_ok(lit_t'(lit_in), NUM_VARS);
    assign accept       = lit_valid & lit_ready;
    assign good         = accept & lit_in_range & ~dup;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (v_abs == LIT_W'(i + 1))
                dup = lit_neg ? neg_seen[i] : pos_seen[i];
        end
    end

    literal_comp_table #(
        .NUM_VARS (NUM_VARS),
        .COMP_W   (COMP_W),
        .VAR_W    (VAR_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .clear       (restart),
        .we          (good),
        .wr_var      (VAR_W'(v_abs)),
        .wr_neg      (lit_neg),
        .wr_comp     (comp_cnt),
        .rd_var      (var_idx),
        .rd_pos_comp (rd_pos_comp),
        .rd_neg_comp (rd_neg_comp),
        .rd_pos_seen (rd_pos_seen),
        .rd_neg_seen (rd_neg_seen),
        .pos_seen    (pos_seen),
        .neg_seen    (neg_seen)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = COLLECT;
        end else begin
            unique case (state)
                COLLECT: if (stream_done) state_nxt = CHECK;
                CHECK:   if (var_idx == VAR_W'(NUM_VARS)) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_cnt    <= '0;
            var_idx     <= VAR_W'(1);
            sat         <= 1'b1;
            assignment  <= '0;
            err_bad_lit <= 1'b0;
        end else if (restart) begin
            comp_cnt    <= '0;
            var_idx     <= VAR_W'(1);
            sat         <= 1'b1;
            assignment  <= '0;
            err_bad_lit <= 1'b0;
        end else begin
            if (accept && !good)
                err_bad_lit <= 1'b1;
            // Bad beats still close their SCC so later indices stay aligned
            if (accept && lit_last && comp_cnt != COMP_MAX)
                comp_cnt <= comp_cnt + 1'b1;
            if (state == CHECK) begin
                if (rd_pos_seen && rd_neg_seen && rd_pos_comp == rd_neg_comp)
                    sat <= 1'b0;
                for (int i = 0; i < NUM_VARS; i++) begin
                    if (var_idx == VAR_W'(i + 1))
                        assignment[i] <= rd_pos_seen &
                            (~rd_neg_seen | (rd_pos_comp > rd_neg_comp));
                end
                if (var_idx != VAR_W'(NUM_VARS))
                    var_idx <= var_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scc_assignment_extractor.sv
// Self-checking bench for scc_assignment_extractor: directed scenarios
// plus randomized SCC streams checked against a reference model.
module tb_scc_assignment_extractor;

    localparam int NV  = 3;
    localparam int LAT = NV + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              restart = 1'b0;
    logic              lit_valid = 1'b0;
    logic              lit_ready;
    logic signed [7:0] lit_in = '0;
    logic              lit_last = 1'b0;
    logic              stream_done = 1'b0;
    logic              busy;
    logic              result_valid;
    logic              sat;
    logic [NV-1:0]     assignment;
    logic              err_bad_lit;

    int errors = 0;
    int checks = 0;

    int q_lit[$];
    bit q_last[$];

    scc_assignment_extractor #(.NUM_VARS(NV), .LIT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .lit_valid    (lit_valid),
        .lit_ready    (lit_ready),
        .lit_in       (lit_in),
        .lit_last     (lit_last),
        .stream_done  (stream_done),
        .busy         (busy),
        .result_valid (result_valid),
        .sat          (sat),
        .assignment   (assignment),
        .err_bad_lit  (err_bad_lit)
    );

    always #5 clk = ~clk;

    // Reference: SCC index = number of closed SCCs before the beat;
    // x_v true iff its positive literal sits in a later SCC than its negation.
    task automatic model(output bit es, output logic [NV-1:0] ea, output bit ee);
        int pc[NV+1];
        int nc[NV+1];
        bit ps[NV+1];
        bit ns[NV+1];
        int comp;
        comp = 0;
        es = 1'b1;
        ea = '0;
        ee = 1'b0;
        for (int v = 0; v <= NV; v++) begin
            pc[v] = 0; nc[v] = 0; ps[v] = 0; ns[v] = 0;
        end
        for (int i = 0; i < q_lit.size(); i++) begin
            int l;
            int v;
            l = q_lit[i];
            v = (l < 0) ? -l : l;
            if (l == 0 || v > NV) begin
                ee = 1'b1;
            end else if (l > 0) begin
                if (ps[v]) ee = 1'b1;
                else begin pc[v] = comp; ps[v] = 1'b1; end
            end else begin
                if (ns[v]) ee = 1'b1;
                else begin nc[v] = comp; ns[v] = 1'b1; end
            end
            if (q_last[i] && comp < 2 * NV) comp++;
        end
        for (int v = 1; v <= NV; v++) begin
            if (ps[v] && ns[v] && pc[v] == nc[v]) es = 1'b0;
            ea[v-1] = ps[v] && (!ns[v] || pc[v] > nc[v]);
        end
    endtask

    task automatic push(input int l, input bit last);
        q_lit.push_back(l);
        q_last.push_back(last);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        q_lit.delete();
        q_last.delete();
    endtask

    task automatic beat(input int l, input bit last, input bit done);
        lit_valid = 1'b1;
        lit_in = 8'(l);
        lit_last = last;
        stream_done = done;
        @(posedge clk); #1;
        lit_valid = 1'b0;
        lit_last = 1'b0;
        stream_done = 1'b0;
    endtask

    task automatic feed(input int from, input bit coincident);
        for (int i = from; i < q_lit.size(); i++)
            beat(q_lit[i], q_last[i], coincident && (i == q_lit.size() - 1));
        if (!coincident) begin
            stream_done = 1'b1;
            @(posedge clk); #1;
            stream_done = 1'b0;
        end
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic push_scen1();
        push(-2, 1); push(-1, 1); push(1, 1);
        push(2, 1); push(-3, 1); push(3, 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({lit_ready, busy, result_valid, sat, assignment, err_bad_lit}
            !== {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b rv=%b sat=%b asg=%b err=%b",
                     lit_ready, busy, result_valid, sat, assignment, err_bad_lit);
        end
    endtask

    task automatic test_satisfiable();
        int lat;
        do_restart();
        push_scen1();
        feed(0, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || lit_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_busy: busy=%b rdy=%b want 1 0", busy, lit_ready);
        end
        lat = 1;
        while (!result_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (sat !== 1'b1 || assignment !== 3'b111) begin
            errors++;
            $display("FAIL sat_result: sat=%b asg=%b want 1 111", sat, assignment);
        end
    endtask

    task automatic test_contradiction();
        int lat;
        do_restart();
        push(1, 0); push(-1, 1); push(2, 1);
        push(-2, 1); push(3, 1); push(-3, 1);
        feed(0, 1'b0);
        wait_result(lat);
        checks++;
        if (lat != LAT || sat !== 1'b0 || assignment !== 3'b000) begin
            errors++;
            $display("FAIL contradiction: lat=%0d sat=%b asg=%b want %0d 0 000",
                     lat, sat, assignment, LAT);
        end
    endtask

    task automatic test_bad_lits();
        int lat;
        bit es;
        bit ee;
        logic [NV-1:0] ea;
        do_restart();
        push(-2, 1); push(0, 0); push(-1, 1); push(4, 0);
        push(1, 1); push(2, 1); push(2, 0); push(-3, 1); push(3, 1);
        beat(q_lit[0], q_last[0], 1'b0);
        @(negedge clk);
        checks++;
        if (err_bad_lit !== 1'b0) begin
            errors++;
            $display("FAIL bad_pre: err=%b want 0", err_bad_lit);
        end
        beat(q_lit[1], q_last[1], 1'b0);
        @(negedge clk);
        checks++;
        if (err_bad_lit !== 1'b1) begin
            errors++;
            $display("FAIL bad_zero: err=%b want 1", err_bad_lit);
        end
        feed(2, 1'b0);
        wait_result(lat);
        model(es, ea, ee);
        checks++;
        if (lat != LAT || sat !== es || assignment !== ea || err_bad_lit !== ee) begin
            errors++;
            $display("FAIL bad_result: lat=%0d sat=%b asg=%b err=%b want %b %b %b",
                     lat, sat, assignment, err_bad_lit, es, ea, ee);
        end
    endtask

    task automatic test_coincident();
        int lat;
        do_restart();
        push_scen1();
        feed(0, 1'b1);
        wait_result(lat);
        checks++;
        if (lat != LAT || sat !== 1'b1 || assignment !== 3'b111) begin
            errors++;
            $display("FAIL coincident: lat=%0d sat=%b asg=%b want %0d 1 111",
                     lat, sat, assignment, LAT);
        end
    endtask

    task automatic test_abort();
        int lat;
        do_restart();
        push_scen1();
        feed(0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (result_valid !== 1'b0 || sat !== 1'b1 || lit_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: rv=%b sat=%b rdy=%b busy=%b want 0 1 1 0",
                     result_valid, sat, lit_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        feed(0, 1'b0);
        wait_result(lat);
        checks++;
        if (lat != LAT || sat !== 1'b1 || assignment !== 3'b111) begin
            errors++;
            $display("FAIL abort_replay: lat=%0d sat=%b asg=%b want %0d 1 111",
                     lat, sat, assignment, LAT);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad;
        do_restart();
        push_scen1();
        feed(0, 1'b0);
        // Duplicate literal held during CHECK/DONE would flag err if accepted
        lit_valid = 1'b1;
        lit_in = -8'sd1;
        lit_last = 1'b1;
        wait_result(lat);
        bad = 1'b0;
        for (int n = 0; n < 6; n++) begin
            stream_done = n[0];
            @(negedge clk);
            if (result_valid !== 1'b1 || lit_ready !== 1'b0 || sat !== 1'b1 ||
                assignment !== 3'b111 || err_bad_lit !== 1'b0)
                bad = 1'b1;
        end
        stream_done = 1'b0;
        checks++;
        if (lat != LAT || bad) begin
            errors++;
            $display("FAIL hold: lat=%0d rv=%b rdy=%b sat=%b asg=%b err=%b",
                     lat, result_valid, lit_ready, sat, assignment, err_bad_lit);
        end
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        lit_valid = 1'b0;
        lit_last = 1'b0;
        @(negedge clk);
        checks++;
        if (lit_ready !== 1'b1 || result_valid !== 1'b0 || sat !== 1'b1 ||
            assignment !== 3'b000 || err_bad_lit !== 1'b0) begin
            errors++;
            $display("FAIL restart: rdy=%b rv=%b sat=%b asg=%b err=%b",
                     lit_ready, result_valid, sat, assignment, err_bad_lit);
        end
    endtask

    task automatic test_random();
        int lits[2*NV];
        int lat;
        bit es;
        bit ee;
        logic [NV-1:0] ea;
        for (int it = 0; it < 20; it++) begin
            do_restart();
            for (int k = 0; k < 2 * NV; k++)
                lits[k] = (k % 2 == 0) ? (k / 2 + 1) : -(k / 2 + 1);
            for (int k = 2 * NV - 1; k > 0; k--) begin
                int j;
                int t;
                j = $urandom_range(0, k);
                t = lits[k]; lits[k] = lits[j]; lits[j] = t;
            end
            for (int k = 0; k < 2 * NV; k++) begin
                if ($urandom_range(0, 7) == 0) continue;
                if ($urandom_range(0, 5) == 0) begin
                    int b;
                    b = $urandom_range(0, 2);
                    push(b == 0 ? 0 : (b == 1 ? 4 + int'($urandom_range(0, 3)) : -5),
                         1'($urandom_range(0, 1)));
                end
                push(lits[k], 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 7) == 0) push(lits[k], 1'b0);
            end
            if (q_lit.size() == 0) push(1, 1);
            model(es, ea, ee);
            feed(0, 1'($urandom_range(0, 1)));
            wait_result(lat);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, LAT);
            end
            checks++;
            if (sat !== es) begin
                errors++;
                $display("FAIL rnd%0d_sat: got %b want %b", it, sat, es);
            end
            checks++;
            if (assignment !== ea) begin
                errors++;
                $display("FAIL rnd%0d_assign: got %b want %b", it, assignment, ea);
            end
            checks++;
            if (err_bad_lit !== ee) begin
                errors++;
                $display("FAIL rnd%0d_err: got %b want %b", it, err_bad_lit, ee);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_satisfiable();
        test_contradiction();
        test_bad_lits();
        test_coincident();
        test_abort();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scc_assignment_extractor.md
Name: scc_assignment_extractor

Overview:
- Downstream stage of the second (reverse-graph) DFS pass in the 2-SAT solver.
- Consumes the SCC stream, one literal per beat, with SCCs in discovery order (topological order of the implication graph's condensation).
- Labels each literal with its SCC index, then scans all variables to decide satisfiability.
- Produces a satisfying assignment: x true iff comp(x) > comp(¬x).

Parameters:
- NUM_VARS, 3, number of boolean variables; literals are ±1..±NUM_VARS (matches Nodes=6).
- LIT_W, 8, signed literal width.
- COMP_W, $clog2(2*NUM_VARS+1), SCC index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- restart  in  1  synchronous pulse: clear tables, return to COLLECT
- lit_valid  in  1  literal beat valid
- lit_ready  out  1  high only in COLLECT
- lit_in  in  LIT_W signed  literal; positive = x, negative = ¬x
- lit_last  in  1  qualifies the beat as the last literal of the current SCC
- stream_done  in  1  pulse: all SCCs delivered
- busy  out  1  high in CHECK
- result_valid  out  1  high in DONE, held
- sat  out  1  formula satisfiable; valid when result_valid
- assignment  out  NUM_VARS  bit v-1 = value of x_v; valid when result_valid
- err_bad_lit  out  1  sticky: zero, out-of-range or duplicate literal received

Behaviour:
- Reset values (async reset):
  - state=COLLECT, comp_cnt=0, all seen bits 0, var_idx=1.
  - lit_ready=1, busy=0, result_valid=0, sat=1, assignment=0, err_bad_lit=0.
- States: COLLECT -> CHECK -> DONE.
  - restart, from any state, synchronously reproduces the reset values.
  - restart has priority over all other inputs.
- COLLECT:
  - Accept a beat when lit_valid & lit_ready.
  - v = |lit_in|. If lit_in==0, v>NUM_VARS, or that polarity is already seen: beat is ignored, err_bad_lit<=1, and lit_last still advances comp_cnt.
  - Otherwise write comp_cnt into pos_comp[v] or neg_comp[v] and set the matching seen bit.
  - Accepted beat with lit_last: comp_cnt+1, saturating at 2*NUM_VARS.
  - stream_done: go to CHECK next cycle. A literal accepted in the same cycle is recorded first.
- CHECK:
  - lit_ready=0; lit_valid and stream_done are ignored.
  - One variable per cycle, var_idx = 1..NUM_VARS.
  - If pos_seen & neg_seen & pos_comp==neg_comp: sat<=0. This is sticky until reset/restart.
  - assignment[v-1] <= pos_seen & (!neg_seen | pos_comp > neg_comp). Comparison is unsigned COMP_W.
  - After var_idx==NUM_VARS, go to DONE.
  - Latency: stream_done accepted in cycle t gives result_valid=1 at t+1+NUM_VARS.
- DONE:
  - result_valid=1; sat and assignment are stable.
  - lit_ready=0; inputs are ignored until restart or reset.
- Reset or restart mid-COLLECT/CHECK aborts; partial results are never exposed.
- assignment is not forced to 0 when sat=0. Consumers must gate it with sat.

Decomposition:
- Shared package sat_pkg holds:
  - typedef lit_t (signed LIT_W).
  - enum extract_state_t {COLLECT, CHECK, DONE}.
  - function lit_var(lit) returning |lit|.
  - function lit_ok(lit, NUM_VARS).
- One sub-module, literal_comp_table:
  - Register array indexed by variable, storing pos/neg comp index plus seen bits.
  - One write port (polarity select), one read port by var_idx.
  - Synchronous clear on restart, async clear on reset.
- Target size ~200 lines total.

Test Plan:
1. Satisfiable case.
   - Stimulus: SCCs {-2},{-1},{1},{2},{-3},{3}, each single-beat with lit_last=1, then stream_done.
   - Required: result_valid 4 cycles later; sat=1; assignment=3'b111.
2. Contradiction.
   - Stimulus: SCCs {1,-1} as beats 1 then -1(last), then {2},{-2},{3},{-3}, then stream_done.
   - Required: sat=0; assignment[1]=0 (comp 1 > 2 false); assignment[2]=0.
3. Bad literals.
   - Stimulus: lit_in=0, then 4, then a second 2 within a valid stream.
   - Required: err_bad_lit=1 after the first bad beat; tables unchanged; the remaining valid stream still gives the correct sat/assignment.
4. Coincident stream_done.
   - Stimulus: stream_done in the same cycle as the final beat 3(last).
   - Required: pos_comp[3] is recorded, and assignment[2] reflects it.
5. Abort during CHECK.
   - Stimulus: reset asserted in the 2nd CHECK cycle, then a full replay of scenario 1.
   - Required: immediately result_valid=0, sat=1, lit_ready=1; the replay again gives 3'b111.
6. Backpressure and restart.
   - Stimulus: lit_valid held high during CHECK/DONE.
   - Required: no beats accepted and outputs stable; restart returns lit_ready=1 next cycle with result_valid=0.
